nf10_upb_input_arbiter: RTL and testbench
=========================================

# nf10_upb_input_arbiter

- Packet-granular round-robin arbiter: shares the single 256-bit switch-pipeline input stream between NUM_INPUTS requesters (10G MAC converters plus the DMA input converter).
- Sits between the per-port 256-bit converters and the OpenFlow lookup pipeline.
- Once an input is granted, its whole packet passes through unbroken up to tlast; then the grant rotates.

## Interface
Parameters:
- NUM_INPUTS, 5, number of requesters, legal 2..8; index NUM_INPUTS-1 is the DMA input by convention.

Ports (N = NUM_INPUTS):
- CLK  in  1  sole clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  N*256  flattened; input i occupies [i*256 +: 256].
- s_axis_tkeep  in  N*32  byte enables per input.
- s_axis_tuser_in_port  in  N*3  per input.
- s_axis_tuser_in_vport  in  N*3  per input.
- s_axis_tuser_out_port  in  N*8  per input.
- s_axis_tuser_out_vport  in  N*8  per input.
- s_axis_tuser_packet_length  in  N*14  per input.
- s_axis_tvalid  in  N  one bit per input.
- s_axis_tlast  in  N  one bit per input.
- s_axis_tready  out  N  one bit per input.
- m_axis_tdata / tkeep / tuser_in_port / tuser_in_vport / tuser_out_port / tuser_out_vport / tuser_packet_length  out  256 / 32 / 3 / 3 / 8 / 8 / 14  granted input's fields.
- m_axis_tvalid  out  1.
- m_axis_tlast  out  1.
- m_axis_tready  in  1.
- busy  out  1  high while in PASS.
- grant_idx  out  3  currently or last granted input.

## Operation
- States:
  - IDLE: no grant.
  - PASS: grant held by grant_idx.
- IDLE:
  - Search inputs starting at last_grant+1, modulo N, wrapping.
  - The first i with s_axis_tvalid[i]=1 wins: grant_idx<=i, last_grant<=i, state<=PASS.
  - No valid input: remain in IDLE.
  - No beat is transferred in IDLE.
- PASS (combinational datapath):
  - All m_axis_* data, tuser, tvalid and tlast = input grant_idx's signals.
  - s_axis_tready[grant_idx] = m_axis_tready; all other s_axis_tready = 0.
- Beat transfer: m_axis_tvalid & m_axis_tready.
  - On a transfer with m_axis_tlast=1: state<=IDLE.
  - Otherwise stay in PASS.
- Granted input dropping tvalid mid-packet: grant is held, m_axis_tvalid=0, no timeout.
- Single-beat packet (tlast on first beat): PASS lasts exactly one transfer cycle.
- tuser fields pass through unmodified on every beat; no consistency check across beats.
- Ungranted inputs must hold their data; the block never drops or reorders beats.

## Timing
- Reset values:
  - state=IDLE, last_grant=N-1 (so input 0 has first priority), grant_idx=0, busy=0.
  - m_axis_tvalid=0, m_axis_tlast=0, all s_axis_tready=0.
  - m_axis data outputs are 0 while in IDLE.
- Arbitration latency:
  - Grant is registered one cycle after tvalid is seen in IDLE.
  - The first beat can transfer in the following cycle.
  - One bubble cycle between consecutive packets.
- Sustained throughput: one beat/cycle within a packet.
- Reset asserted mid-packet:
  - Next cycle is IDLE with reset values.
  - The partial packet is abandoned; recovery is the upstream's responsibility.
- Simultaneous requests: strictly round-robin. Input i regains priority only after every other requesting input has been served once.

## Configuration
- Macro: UPB_INPUT_ARBITER_STATS_EN.
- Defined:
  - Adds output pkt_count, width N*32; input i's counter occupies [i*32 +: 32].
  - Counter i increments on each tlast transfer from input i.
  - Counters wrap at 2^32-1 to 0 and clear on axi_reset.
- Undefined: port and counters absent; arbitration behaviour identical.

## Test plan
- Single input: input 1 sends a 3-beat packet, tdata 0x11/0x12/0x13, last tkeep 0x1FFFFFFF, m_axis_tready=1. Required:
  - grant_idx=1.
  - 3 output beats identical to input.
  - busy high for 3 cycles.
  - returns to IDLE.
- Round-robin: all 5 inputs hold 2-beat packets after reset. Required:
  - Service order 0,1,2,3,4,0.
  - Exactly one bubble cycle between packets.
- Backpressure and gaps:
  - m_axis_tready toggles every cycle and the granted input drops tvalid for 4 cycles mid-packet.
  - Required: no beat lost or duplicated, no other input's s_axis_tready asserted, grant held throughout.
- Single-beat packets:
  - Inputs 2 and 4 each offer 1-beat packets continuously.
  - Required: alternating grants 2,4,2,4; each PASS lasts 1 cycle.
- Reset mid-packet:
  - Assert axi_reset during beat 2 of a 4-beat packet from input 3.
  - Required next cycle: m_axis_tvalid=0, busy=0, s_axis_tready=0.
  - Required afterwards: the next arbitration starts from input 0.
- Stats (macro defined):
  - Send 3 packets from input 0 and 1 from DMA input 4.
  - Required: pkt_count[31:0]=3, pkt_count[159:128]=1, pkt_count=0 after reset.

Source files
------------

// File: rtl/nf10_upb_input_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS 256-bit AXI-Stream inputs into one.
// Optional per-input packet counters are enabled with UPB_INPUT_ARBITER_STATS_EN.
module nf10_upb_input_arbiter #(
   parameter int unsigned NUM_INPUTS = 5
) (
   input  logic                         CLK,
   input  logic                         axi_reset,
   input  logic [NUM_INPUTS*256-1:0]    s_axis_tdata,
   input  logic [NUM_INPUTS*32-1:0]     s_axis_tkeep,
   input  logic [NUM_INPUTS*3-1:0]      s_axis_tuser_in_port,
   input  logic [NUM_INPUTS*3-1:0]      s_axis_tuser_in_vport,
   input  logic [NUM_INPUTS*8-1:0]      s_axis_tuser_out_port,
   input  logic [NUM_INPUTS*8-1:0]      s_axis_tuser_out_vport,
   input  logic [NUM_INPUTS*14-1:0]     s_axis_tuser_packet_length,
   input  logic [NUM_INPUTS-1:0]        s_axis_tvalid,
   input  logic [NUM_INPUTS-1:0]        s_axis_tlast,
   output logic [NUM_INPUTS-1:0]        s_axis_tready,
   output logic [255:0]                 m_axis_tdata,
   output logic [31:0]                  m_axis_tkeep,
   output logic [2:0]                   m_axis_tuser_in_port,
   output logic [2:0]                   m_axis_tuser_in_vport,
   output logic [7:0]                   m_axis_tuser_out_port,
   output logic [7:0]                   m_axis_tuser_out_vport,
   output logic [13:0]                  m_axis_tuser_packet_length,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   output logic                         busy,
   output logic [2:0]                   grant_idx
`ifdef UPB_INPUT_ARBITER_STATS_EN
   ,
   output logic [NUM_INPUTS*32-1:0]     pkt_count
`endif
);

   localparam int unsigned N  = NUM_INPUTS;
   localparam int unsigned DW = 256;
   localparam int unsigned KW = 32;
   localparam int unsigned CW = 32;

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

   state_t     state;
   logic [2:0] last_grant;
   logic       found;
   logic [2:0] pick;
   logic       xfer_last;

   // Round-robin search: first valid input after last_grant, wrapping modulo N.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && s_axis_tvalid[i] && (((32'(last_grant) + k) % N) == i)) begin
               found = 1'b1;
               pick  = 3'(i);
            end
         end
      end
   end

   // Granted input's stream is steered straight to the output; everything is zero when idle.
   always_comb begin
      m_axis_tdata               = '0;
      m_axis_tkeep               = '0;
      m_axis_tuser_in_port       = '0;
      m_axis_tuser_in_vport      = '0;
      m_axis_tuser_out_port      = '0;
      m_axis_tuser_out_vport     = '0;
      m_axis_tuser_packet_length = '0;
      m_axis_tvalid              = 1'b0;
      m_axis_tlast               = 1'b0;
      s_axis_tready              = '0;
      if (state == PASS) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == 3'(i)) begin
               m_axis_tdata               = s_axis_tdata[i*DW +: DW];
               m_axis_tkeep               = s_axis_tkeep[i*KW +: KW];
               m_axis_tuser_in_port       = s_axis_tuser_in_port[i*3 +: 3];
               m_axis_tuser_in_vport      = s_axis_tuser_in_vport[i*3 +: 3];
               m_axis_tuser_out_port      = s_axis_tuser_out_port[i*8 +: 8];
               m_axis_tuser_out_vport     = s_axis_tuser_out_vport[i*8 +: 8];
               m_axis_tuser_packet_length = s_axis_tuser_packet_length[i*14 +: 14];
               m_axis_tvalid              = s_axis_tvalid[i];
               m_axis_tlast               = s_axis_tlast[i];
               s_axis_tready[i]           = m_axis_tready;
            end
         end
      end
   end

   assign xfer_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Grant FSM: hold the grant until the packet's tlast beat is accepted.
   always_ff @(posedge CLK) begin
      if (axi_reset) begin
         state      <= IDLE;
         last_grant <= 3'(N - 1);
         grant_idx  <= '0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant_idx  <= pick;
                  last_grant <= pick;
                  state      <= PASS;
                  busy       <= 1'b1;
               end
            end
            PASS: begin
               if (xfer_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef UPB_INPUT_ARBITER_STATS_EN
   logic [CW-1:0] pkt_cnt [N];

   // Completed-packet counters per input; wrap naturally at 2^32.
   always_ff @(posedge CLK) begin
      if (axi_reset) begin
         for (int unsigned i = 0; i < N; i++) pkt_cnt[i] <= '0;
      end else if (xfer_last) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == 3'(i)) pkt_cnt[i] <= pkt_cnt[i] + CW'(1);
         end
      end
   end

   always_comb begin
      pkt_count = '0;
      for (int unsigned i = 0; i < N; i++) pkt_count[i*CW +: CW] = pkt_cnt[i];
   end
`endif

endmodule

// File: tb/tb_nf10_upb_input_arbiter.sv
// Scoreboard bench for nf10_upb_input_arbiter: per-input beat sources, expected-beat queue, monitor.
module tb_nf10_upb_input_arbiter;

   localparam int N = 5;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic [2:0]   in_port;
      logic [2:0]   in_vport;
      logic [7:0]   out_port;
      logic [7:0]   out_vport;
      logic [13:0]  len;
      logic         last;
      logic [2:0]   src;
   } beat_t;

   logic              clk;
   logic              axi_reset;
   logic [N*256-1:0]  s_axis_tdata;
   logic [N*32-1:0]   s_axis_tkeep;
   logic [N*3-1:0]    s_axis_tuser_in_port;
   logic [N*3-1:0]    s_axis_tuser_in_vport;
   logic [N*8-1:0]    s_axis_tuser_out_port;
   logic [N*8-1:0]    s_axis_tuser_out_vport;
   logic [N*14-1:0]   s_axis_tuser_packet_length;
   logic [N-1:0]      s_axis_tvalid;
   logic [N-1:0]      s_axis_tlast;
   logic [N-1:0]      s_axis_tready;
   logic [255:0]      m_axis_tdata;
   logic [31:0]       m_axis_tkeep;
   logic [2:0]        m_axis_tuser_in_port;
   logic [2:0]        m_axis_tuser_in_vport;
   logic [7:0]        m_axis_tuser_out_port;
   logic [7:0]        m_axis_tuser_out_vport;
   logic [13:0]       m_axis_tuser_packet_length;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic              busy;
   logic [2:0]        grant_idx;
`ifdef UPB_INPUT_ARBITER_STATS_EN
   logic [N*32-1:0]   pkt_count;
`endif

   nf10_upb_input_arbiter #(.NUM_INPUTS(N)) dut (
      .CLK                        (clk),
      .axi_reset                  (axi_reset),
      .s_axis_tdata               (s_axis_tdata),
      .s_axis_tkeep               (s_axis_tkeep),
      .s_axis_tuser_in_port       (s_axis_tuser_in_port),
      .s_axis_tuser_in_vport      (s_axis_tuser_in_vport),
      .s_axis_tuser_out_port      (s_axis_tuser_out_port),
      .s_axis_tuser_out_vport     (s_axis_tuser_out_vport),
      .s_axis_tuser_packet_length (s_axis_tuser_packet_length),
      .s_axis_tvalid              (s_axis_tvalid),
      .s_axis_tlast               (s_axis_tlast),
      .s_axis_tready              (s_axis_tready),
      .m_axis_tdata               (m_axis_tdata),
      .m_axis_tkeep               (m_axis_tkeep),
      .m_axis_tuser_in_port       (m_axis_tuser_in_port),
      .m_axis_tuser_in_vport      (m_axis_tuser_in_vport),
      .m_axis_tuser_out_port      (m_axis_tuser_out_port),
      .m_axis_tuser_out_vport     (m_axis_tuser_out_vport),
      .m_axis_tuser_packet_length (m_axis_tuser_packet_length),
      .m_axis_tvalid              (m_axis_tvalid),
      .m_axis_tlast               (m_axis_tlast),
      .m_axis_tready              (m_axis_tready),
      .busy                       (busy),
      .grant_idx                  (grant_idx)
`ifdef UPB_INPUT_ARBITER_STATS_EN
      ,
      .pkt_count                  (pkt_count)
`endif
   );

   int    n_checks = 0;
   int    n_pass   = 0;

   beat_t mem [N][16];
   int    head [N];
   int    tail [N];
   int    hold_at [N];
   int    hold_left [N];
   beat_t exp_q [$];
   int    gaps [$];
   int    cyc = 0;
   int    last_end = -1;
   bit    in_pkt = 0;
   int    busy_cnt = 0;
   int    rx_total = 0;
   bit    stray = 0;
   bit    rdy_mode = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // Queue one packet on input src and its expected beats on the scoreboard.
   task automatic enq(input int src, input int nb, input logic [255:0] base, input logic [31:0] lkeep);
      beat_t b;
      for (int k = 0; k < nb; k++) begin
         b.data      = base + 256'(k);
         b.keep      = (k == nb - 1) ? lkeep : 32'hFFFF_FFFF;
         b.in_port   = 3'(src);
         b.in_vport  = 3'(src + 1);
         b.out_port  = 8'(8'd1 << src);
         b.out_vport = 8'(k);
         b.len       = 14'(nb * 32);
         b.last      = (k == nb - 1);
         b.src       = 3'(src);
         mem[src][tail[src] % 16] = b;
         tail[src]++;
         exp_q.push_back(b);
      end
   endtask

   task automatic reset_mon();
      gaps.delete();
      last_end = -1;
      in_pkt   = 0;
      busy_cnt = 0;
      stray    = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      axi_reset = 1'b1;
      @(posedge clk); #2;
      axi_reset = 1'b0;
      reset_mon();
   endtask

   task automatic drain(input string name);
      bit done = 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         @(posedge clk); #2;
         done = (exp_q.size() == 0);
         for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 0;
      end
      if (!done) check({name, "_drain_timeout"}, 256'(exp_q.size()), 256'd0);
      repeat (3) @(negedge clk);
   endtask

   // Input driver: retire beats that handshook on the last edge, then present each source's head.
   initial begin : driver
      logic [N-1:0] hs;
      s_axis_tdata = '0; s_axis_tkeep = '0;
      s_axis_tuser_in_port = '0; s_axis_tuser_in_vport = '0;
      s_axis_tuser_out_port = '0; s_axis_tuser_out_vport = '0;
      s_axis_tuser_packet_length = '0;
      s_axis_tvalid = '0; s_axis_tlast = '0;
      forever begin
         @(negedge clk);
         hs = s_axis_tvalid & s_axis_tready;
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            beat_t b;
            if (hs[i]) head[i]++;
            if (head[i] != tail[i] && !(hold_left[i] > 0 && head[i] == hold_at[i])) begin
               b = mem[i][head[i] % 16];
               s_axis_tdata[i*256 +: 256]             = b.data;
               s_axis_tkeep[i*32 +: 32]               = b.keep;
               s_axis_tuser_in_port[i*3 +: 3]         = b.in_port;
               s_axis_tuser_in_vport[i*3 +: 3]        = b.in_vport;
               s_axis_tuser_out_port[i*8 +: 8]        = b.out_port;
               s_axis_tuser_out_vport[i*8 +: 8]       = b.out_vport;
               s_axis_tuser_packet_length[i*14 +: 14] = b.len;
               s_axis_tlast[i]                        = b.last;
               s_axis_tvalid[i]                       = 1'b1;
            end else begin
               s_axis_tvalid[i] = 1'b0;
               if (head[i] != tail[i]) hold_left[i]--;
            end
         end
      end
   end

   initial begin : ready_gen
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_axis_tready = rdy_mode ? ~m_axis_tready : 1'b1;
      end
   end

   // Monitor: every accepted output beat is popped from the scoreboard and compared.
   initial begin : monitor
      beat_t e;
      logic [N-1:0] own;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         own = busy ? N'(1) << grant_idx : '0;
         if ((s_axis_tready & ~own) != '0) stray = 1;
         if (m_axis_tvalid && m_axis_tready && !axi_reset) begin
            rx_total++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", m_axis_tdata, 256'd0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", m_axis_tdata, e.data);
               check("beat_side",
                     256'({m_axis_tkeep, m_axis_tuser_in_port, m_axis_tuser_in_vport,
                           m_axis_tuser_out_port, m_axis_tuser_out_vport,
                           m_axis_tuser_packet_length, m_axis_tlast, grant_idx}),
                     256'({e.keep, e.in_port, e.in_vport, e.out_port, e.out_vport,
                           e.len, e.last, e.src}));
            end
            if (!in_pkt) begin
               if (last_end >= 0) gaps.push_back(cyc - last_end - 1);
               in_pkt = 1;
            end
            if (m_axis_tlast) begin
               last_end = cyc;
               in_pkt   = 0;
            end
         end
      end
   end

   initial begin : stimulus
      int bad;
      int base;
      bit hit;
      axi_reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check("rst_tlast",  256'(m_axis_tlast),  256'd0);
      check("rst_busy",   256'(busy),          256'd0);
      check("rst_grant",  256'(grant_idx),     256'd0);
      check("rst_tready", 256'(s_axis_tready), 256'd0);
      check("rst_tdata",  m_axis_tdata,        256'd0);
      @(posedge clk); #2;
      axi_reset = 1'b0;
      reset_mon();

      // Single 3-beat packet from input 1.
      enq(1, 3, 256'h11, 32'h1FFF_FFFF);
      drain("single");
      check("single_busy_cycles", 256'(busy_cnt), 256'd3);
      check("single_grant",       256'(grant_idx), 256'd1);
      check("single_idle_busy",   256'(busy),      256'd0);

      // Round robin: all inputs requesting, input 0 has a second packet.
      do_reset();
      enq(0, 2, 256'h100, 32'hFFFF);
      enq(1, 2, 256'h110, 32'hFFFF);
      enq(2, 2, 256'h120, 32'hFFFF);
      enq(3, 2, 256'h130, 32'hFFFF);
      enq(4, 2, 256'h140, 32'hFFFF);
      enq(0, 2, 256'h150, 32'hFFFF);
      drain("rr");
      bad = 0;
      foreach (gaps[j]) if (gaps[j] != 1) bad++;
      check("rr_gap_count", 256'(gaps.size()), 256'd5);
      check("rr_bad_gaps",  256'(bad),         256'd0);

      // Backpressure with a 4-cycle source gap mid-packet; input 1 waits behind.
      do_reset();
      hold_at[0]   = tail[0] + 2;
      hold_left[0] = 4;
      rdy_mode     = 1;
      enq(0, 6, 256'h300, 32'h00FF);
      enq(1, 2, 256'h310, 32'h0F0F);
      drain("bp");
      rdy_mode = 0;
      check("bp_stray_ready", 256'(stray),        256'd0);
      check("bp_hold_used",   256'(hold_left[0]), 256'd0);

      // Single-beat packets from inputs 2 and 4.
      do_reset();
      enq(2, 1, 256'h400, 32'h1);
      enq(4, 1, 256'h410, 32'h3);
      enq(2, 1, 256'h420, 32'h7);
      enq(4, 1, 256'h430, 32'hF);
      drain("sb");
      bad = 0;
      foreach (gaps[j]) if (gaps[j] != 1) bad++;
      check("sb_busy_cycles", 256'(busy_cnt),    256'd4);
      check("sb_gap_count",   256'(gaps.size()), 256'd3);
      check("sb_bad_gaps",    256'(bad),         256'd0);

      // Reset during beat 2 of a 4-beat packet from input 3.
      do_reset();
      base = rx_total;
      enq(3, 4, 256'h500, 32'hFF);
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(posedge clk); #1;
         hit = (rx_total == base + 1);
      end
      check("mid_rst_reached", 256'(hit), 256'd1);
      axi_reset = 1'b1;
      @(posedge clk); #2;
      axi_reset = 1'b0;
      head[3] = tail[3];
      s_axis_tvalid[3] = 1'b0;
      exp_q.delete();
      reset_mon();
      @(negedge clk);
      check("mid_rst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check("mid_rst_busy",   256'(busy),          256'd0);
      check("mid_rst_tready", 256'(s_axis_tready), 256'd0);
      @(posedge clk); #2;
      enq(0, 1, 256'h600, 32'h1);
      enq(4, 1, 256'h610, 32'h1);
      drain("post_rst");

`ifdef UPB_INPUT_ARBITER_STATS_EN
      do_reset();
      @(negedge clk);
      check("stats_clear", 256'(pkt_count), 256'd0);
      @(posedge clk); #2;
      enq(0, 2, 256'h700, 32'h1);
      enq(4, 2, 256'h710, 32'h1);
      enq(0, 2, 256'h720, 32'h1);
      enq(0, 2, 256'h730, 32'h1);
      drain("stats");
      check("stats_in0", 256'(pkt_count[31:0]),    256'd3);
      check("stats_in4", 256'(pkt_count[159:128]), 256'd1);
      do_reset();
      @(negedge clk);
      check("stats_reset", 256'(pkt_count), 256'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
